// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI burst decoder: FSM state encoding and
// header-length / width arithmetic used to size the deserialiser.
package spi_pkg;

    typedef enum logic {
        HEADER = 1'b0,
        DATA   = 1'b1
    } spi_state_e;

    function automatic int spi_hdr_w(input int addr_w);
        return 1 + addr_w;
    endfunction

    function automatic int spi_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_deser.sv
// Serial-in shift register plus bit counter; both clear synchronously, and the
// counter returns to zero on 'wrap' so the caller controls field lengths.
module spi_deser #(
    parameter int SH_W  = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wrap,
    input  logic             din,
    output logic [CNT_W-1:0] cnt,
    output logic [SH_W-1:0]  shift
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt   <= '0;
            shift <= '0;
        end else begin
            shift <= {shift[SH_W-2:0], din};
            cnt   <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_burst_decoder.sv
// SPI header/data burst decoder in the spi_clk domain with write and read-prefetch
// strobes. Define SPI_FRAME_ERR_EN to add the sticky frame_err output.
module spi_burst_decoder
    import spi_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int AUTO_INC = 1
) (
    input  logic              spi_clk,
    input  logic              rst,
    input  logic              csb,
    input  logic              pico,
    output logic              is_write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              hdr_valid,
    output logic              wr_stb,
    output logic              rd_stb
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int HDR_W = spi_hdr_w(ADDR_W);
    localparam int MAX_W = spi_max(HDR_W, DATA_W);
    localparam int CNT_W = $clog2(MAX_W);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    spi_state_e        state;
    spi_state_e        next_state;
    logic [CNT_W-1:0]  cnt;
    logic [MAX_W-1:0]  shift;
    logic              hdr_done;
    logic              word_done;
    logic [HDR_W-1:0]  hdr_word;
    logic [DATA_W-1:0] data_word;
    logic              word_idx;
    logic              frame_clr;

    assign frame_clr = rst | csb;

    spi_deser #(
        .SH_W  (MAX_W),
        .CNT_W (CNT_W)
    ) u_deser (
        .clk   (spi_clk),
        .clr   (frame_clr),
        .wrap  (hdr_done | word_done),
        .din   (pico),
        .cnt   (cnt),
        .shift (shift)
    );

    always_ff @(posedge spi_clk) begin
        if (frame_clr) begin
            state <= HEADER;
        end else begin
            state <= next_state;
        end
    end

    // The last bit of each field comes straight from pico so no word lags by one.
    always_comb begin
        next_state = state;
        hdr_done   = 1'b0;
        word_done  = 1'b0;
        hdr_word   = {shift[HDR_W-2:0], pico};
        data_word  = {shift[DATA_W-2:0], pico};
        if (state == HEADER) begin
            hdr_done = (cnt == HDR_LAST);
            if (hdr_done) begin
                next_state = DATA;
            end
        end else begin
            word_done = (cnt == DATA_LAST);
        end
    end

    always_ff @(posedge spi_clk) begin
        if (frame_clr) begin
            is_write  <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            hdr_valid <= 1'b0;
            wr_stb    <= 1'b0;
            rd_stb    <= 1'b0;
            word_idx  <= 1'b0;
        end else begin
            hdr_valid <= 1'b0;
            wr_stb    <= 1'b0;
            rd_stb    <= 1'b0;
            if (hdr_done) begin
                is_write  <= hdr_word[HDR_W-1];
                addr      <= hdr_word[ADDR_W-1:0];
                hdr_valid <= 1'b1;
                rd_stb    <= ~hdr_word[HDR_W-1];
                word_idx  <= 1'b0;
            end else if (word_done) begin
                // Writes bump the address before the word lands; reads prefetch the next one.
                if (is_write) begin
                    wdata  <= data_word;
                    wr_stb <= 1'b1;
                    if (word_idx && (AUTO_INC != 0)) begin
                        addr <= addr + ADDR_W'(1);
                    end
                end else if (AUTO_INC != 0) begin
                    addr   <= addr + ADDR_W'(1);
                    rd_stb <= 1'b1;
                end
                word_idx <= 1'b1;
            end
        end
    end

`ifdef SPI_FRAME_ERR_EN
    always_ff @(posedge spi_clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (csb) begin
            if (cnt != '0) begin
                frame_err <= 1'b1;
            end
        end else if ((state == HEADER) && (cnt == '0)) begin
            frame_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_burst_decoder.sv
// Directed bench for spi_burst_decoder: default-parameter instance driven from a
// frame table plus truncation, and a wide non-incrementing instance with reset.
module tb_spi_burst_decoder;

    logic        spi_clk;
    logic        rst, csb, pico;
    logic        is_write, hdr_valid, wr_stb, rd_stb;
    logic [6:0]  addr;
    logic [7:0]  wdata;

    logic        rst_b, csb_b, pico_b;
    logic        is_write_b, hdr_valid_b, wr_stb_b, rd_stb_b;
    logic [9:0]  addr_b;
    logic [15:0] wdata_b;

`ifdef SPI_FRAME_ERR_EN
    logic        frame_err, frame_err_b;
`endif

    int tests;
    int failures;

    spi_burst_decoder #(.ADDR_W(7), .DATA_W(8), .AUTO_INC(1)) dut_a (
        .spi_clk   (spi_clk),
        .rst       (rst),
        .csb       (csb),
        .pico      (pico),
        .is_write  (is_write),
        .addr      (addr),
        .wdata     (wdata),
        .hdr_valid (hdr_valid),
        .wr_stb    (wr_stb),
        .rd_stb    (rd_stb)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    spi_burst_decoder #(.ADDR_W(10), .DATA_W(16), .AUTO_INC(0)) dut_b (
        .spi_clk   (spi_clk),
        .rst       (rst_b),
        .csb       (csb_b),
        .pico      (pico_b),
        .is_write  (is_write_b),
        .addr      (addr_b),
        .wdata     (wdata_b),
        .hdr_valid (hdr_valid_b),
        .wr_stb    (wr_stb_b),
        .rd_stb    (rd_stb_b)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err (frame_err_b)
`endif
    );

    initial begin
        spi_clk = 1'b0;
        forever #5 spi_clk = ~spi_clk;
    end

    typedef struct {
        string           name;
        logic [7:0]      hdr;
        int              nwords;
        logic [2:0][7:0] data;
        logic            hdr_isw;
        logic [6:0]      hdr_addr;
        logic [2:0]      exp_wr;
        logic [2:0]      exp_rd;
        logic [2:0][6:0] exp_addr;
        logic [2:0][7:0] exp_wdata;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic p);
        @(negedge spi_clk);
        csb  = c;
        pico = p;
        @(posedge spi_clk);
        #1;
    endtask

    task automatic applyStimulusB(input logic c, input logic p, input logic r);
        @(negedge spi_clk);
        csb_b  = c;
        pico_b = p;
        rst_b  = r;
        @(posedge spi_clk);
        #1;
    endtask

    function automatic logic [63:0] outs_a();
        return 64'({is_write, addr, wdata, hdr_valid, wr_stb, rd_stb});
    endfunction

    function automatic logic [63:0] outs_b();
        return 64'({is_write_b, addr_b, wdata_b, hdr_valid_b, wr_stb_b, rd_stb_b});
    endfunction

    initial begin
        int quiet_bad;
        int stray;
        logic [58:0] frame_b;
        logic [7:0]  trunc_hdr;
        logic [10:0] hdr_b;

        tests    = 0;
        failures = 0;
        rst = 1'b1; csb = 1'b1; pico = 1'b0;
        rst_b = 1'b1; csb_b = 1'b1; pico_b = 1'b0;

        //            name        hdr    n  data (w2,w1,w0)       isw   addr   wr      rd      exp_addr (w2,w1,w0)     exp_wdata (w2,w1,w0)
        vecs[0] = '{"wr_burst", 8'h85, 2, {8'h00, 8'hA1, 8'h3C}, 1'b1, 7'h05, 3'b011, 3'b000, {7'h00, 7'h06, 7'h05}, {8'h00, 8'hA1, 8'h3C}};
        vecs[1] = '{"rd_burst", 8'h12, 2, {8'h00, 8'h5A, 8'hFF}, 1'b0, 7'h12, 3'b000, 3'b011, {7'h00, 7'h14, 7'h13}, {8'h00, 8'h00, 8'h00}};
        vecs[2] = '{"wr_wrap",  8'hFF, 2, {8'h00, 8'h22, 8'h11}, 1'b1, 7'h7F, 3'b011, 3'b000, {7'h00, 7'h00, 7'h7F}, {8'h00, 8'h22, 8'h11}};
        vecs[3] = '{"wr_three", 8'h80, 3, {8'h80, 8'h01, 8'hFE}, 1'b1, 7'h00, 3'b111, 3'b000, {7'h02, 7'h01, 7'h00}, {8'h80, 8'h01, 8'hFE}};
        vecs[4] = '{"rd_wrap",  8'h7F, 1, {8'h00, 8'h00, 8'hC3}, 1'b0, 7'h7F, 3'b000, 3'b001, {7'h00, 7'h00, 7'h00}, {8'h00, 8'h00, 8'h00}};

        applyStimulus(1'b1, 1'b0);
        applyStimulusB(1'b1, 1'b0, 1'b1);
        checkOutput("reset_a", outs_a(), 64'(0));
        checkOutput("reset_b", outs_b(), 64'(0));
`ifdef SPI_FRAME_ERR_EN
        checkOutput("reset_frame_err", 64'(frame_err), 64'(0));
`endif
        rst   = 1'b0;
        rst_b = 1'b0;
        applyStimulus(1'b1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            quiet_bad = 0;
            for (int b = 7; b >= 0; b--) begin
                applyStimulus(1'b0, vecs[i].hdr[b]);
                if (b != 0 && (wr_stb || rd_stb || hdr_valid)) quiet_bad++;
            end
            checkOutput($sformatf("%s_hdr", vecs[i].name),
                        64'({hdr_valid, is_write, addr, wr_stb, rd_stb}),
                        64'({1'b1, vecs[i].hdr_isw, vecs[i].hdr_addr, 1'b0, ~vecs[i].hdr_isw}));
            for (int k = 0; k < vecs[i].nwords; k++) begin
                for (int b = 7; b >= 0; b--) begin
                    applyStimulus(1'b0, vecs[i].data[k][b]);
                    if (b != 0 && (wr_stb || rd_stb || hdr_valid)) quiet_bad++;
                end
                checkOutput($sformatf("%s_word%0d", vecs[i].name, k),
                            64'({wr_stb, rd_stb, hdr_valid, addr, wdata}),
                            64'({vecs[i].exp_wr[k], vecs[i].exp_rd[k], 1'b0, vecs[i].exp_addr[k], vecs[i].exp_wdata[k]}));
            end
            checkOutput($sformatf("%s_quiet", vecs[i].name), 64'(quiet_bad), 64'(0));
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("%s_idle", vecs[i].name), outs_a(), 64'(0));
        end

        // Truncated write: header 0x85 then only four data bits.
        trunc_hdr = 8'h85;
        quiet_bad = 0;
        for (int b = 7; b >= 0; b--) applyStimulus(1'b0, trunc_hdr[b]);
        checkOutput("trunc_hdr", 64'({hdr_valid, is_write, addr}), 64'({1'b1, 1'b1, 7'h05}));
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b0, b[0]);
            if (wr_stb || rd_stb || hdr_valid) quiet_bad++;
        end
        checkOutput("trunc_quiet", 64'(quiet_bad), 64'(0));
        applyStimulus(1'b1, 1'b0);
        checkOutput("trunc_cleared", outs_a(), 64'(0));
`ifdef SPI_FRAME_ERR_EN
        checkOutput("trunc_frame_err_set", 64'(frame_err), 64'(1));
`endif
        applyStimulus(1'b1, 1'b0);
        checkOutput("trunc_idle_no_strobe", 64'({wr_stb, rd_stb, hdr_valid}), 64'(0));
`ifdef SPI_FRAME_ERR_EN
        checkOutput("trunc_frame_err_sticky", 64'(frame_err), 64'(1));
`endif
        // Next frame: read header 0x12 whose first bit clears the error.
        trunc_hdr = 8'h12;
        applyStimulus(1'b0, trunc_hdr[7]);
`ifdef SPI_FRAME_ERR_EN
        checkOutput("frame_err_cleared", 64'(frame_err), 64'(0));
`endif
        for (int b = 6; b >= 0; b--) applyStimulus(1'b0, trunc_hdr[b]);
        checkOutput("after_trunc_hdr", 64'({hdr_valid, is_write, addr, rd_stb}), 64'({1'b1, 1'b0, 7'h12, 1'b1}));
        applyStimulus(1'b1, 1'b0);

        // Wide instance, no auto-increment: three write words at header address 0x2A5.
        frame_b = {11'h6A5, 16'h1234, 16'hBEEF, 16'h0F0F};
        stray = 0;
        for (int e = 1; e <= 59; e++) begin
            applyStimulusB(1'b0, frame_b[59-e], 1'b0);
            if (e == 11)
                checkOutput("b_hdr", 64'({hdr_valid_b, is_write_b, addr_b, rd_stb_b}), 64'({1'b1, 1'b1, 10'h2A5, 1'b0}));
            else if (e == 27)
                checkOutput("b_word0", 64'({wr_stb_b, addr_b, wdata_b}), 64'({1'b1, 10'h2A5, 16'h1234}));
            else if (e == 43)
                checkOutput("b_word1", 64'({wr_stb_b, addr_b, wdata_b}), 64'({1'b1, 10'h2A5, 16'hBEEF}));
            else if (e == 59)
                checkOutput("b_word2", 64'({wr_stb_b, addr_b, wdata_b}), 64'({1'b1, 10'h2A5, 16'h0F0F}));
            else if (wr_stb_b || rd_stb_b || hdr_valid_b)
                stray++;
        end
        checkOutput("b_stray_strobes", 64'(stray), 64'(0));
        applyStimulusB(1'b1, 1'b0, 1'b0);
        checkOutput("b_idle", outs_b(), 64'(0));

        // Reset lands on edge 20 of a write frame while csb is still low.
        for (int e = 1; e <= 20; e++) begin
            applyStimulusB(1'b0, frame_b[59-e], (e == 20));
            if (e == 11)
                checkOutput("b_rst_frame_hdr", 64'({hdr_valid_b, addr_b}), 64'({1'b1, 10'h2A5}));
        end
        checkOutput("b_after_rst", outs_b(), 64'(0));
        applyStimulusB(1'b1, 1'b0, 1'b0);

        // Read at 0x3FF: header prefetch strobe only, address held through the word.
        hdr_b = {1'b0, 10'h3FF};
        for (int b = 10; b >= 0; b--) applyStimulusB(1'b0, hdr_b[b], 1'b0);
        checkOutput("b_rd_hdr", 64'({hdr_valid_b, is_write_b, addr_b, rd_stb_b}), 64'({1'b1, 1'b0, 10'h3FF, 1'b1}));
        stray = 0;
        for (int b = 0; b < 16; b++) begin
            applyStimulusB(1'b0, 1'b1, 1'b0);
            if (wr_stb_b || rd_stb_b || hdr_valid_b) stray++;
        end
        checkOutput("b_rd_word_no_strobe", 64'(stray), 64'(0));
        checkOutput("b_rd_word_state", 64'({addr_b, wdata_b}), 64'({10'h3FF, 16'h0000}));
        applyStimulusB(1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
